// File: rtl/ahb_arbiter.sv
// ahb_arbiter: AHB bus arbiter. Shares the bus round-robin between requesting
// masters. Fixed-length bursts and locked sequences keep the current owner,
// and masters that got a SPLIT response stay masked until their slave
// releases them.
module ahb_arbiter #(
   parameter int NUM_MASTERS    = 16,
   parameter int DEFAULT_MASTER = 0,
   parameter int IW             = $clog2(NUM_MASTERS)
) (
   input  logic                   hclk,
   input  logic                   hrst,
   input  logic [NUM_MASTERS-1:0] hbusreq,
   input  logic [NUM_MASTERS-1:0] hlock,
   input  logic [NUM_MASTERS-1:0] hsplit,
   input  logic [1:0]             htrans,
   input  logic [2:0]             hburst,
   input  logic                   hready,
   input  logic [1:0]             hresp,
   output logic [NUM_MASTERS-1:0] hgrant,
   output logic [IW-1:0]          hmaster,
   output logic                   hmastlock
);

   localparam logic [1:0] TR_IDLE    = 2'd0;
   localparam logic [1:0] TR_BUSY    = 2'd1;
   localparam logic [1:0] TR_NONSEQ  = 2'd2;
   localparam logic [1:0] TR_SEQ     = 2'd3;
   localparam logic [1:0] RESP_SPLIT = 2'd3;

   localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
   localparam logic [IW-1:0]          DEF_IDX   = IW'(DEFAULT_MASTER);

   logic [NUM_MASTERS-1:0] r_grant;
   logic [NUM_MASTERS-1:0] r_split_mask;
   logic [IW-1:0]          r_master;
   logic [IW-1:0]          r_rr_ptr;
   logic                   r_mastlock;
   logic                   r_in_split;   // inside a SPLIT response, first cycle already seen
   logic                   r_force_ap;   // next hready edge is an arbitration point regardless of lock
   logic [3:0]             r_beat_cnt;

   logic [NUM_MASTERS-1:0] w_gnt_set;
   logic [NUM_MASTERS-1:0] w_split_nxt;
   logic [IW-1:0]          w_gidx;
   logic [IW-1:0]          w_next_idx;
   logic [IW-1:0]          w_probe;
   logic [3:0]             w_burst_len;
   logic                   w_found;
   logic                   w_lock_hold;
   logic                   w_ap;
   logic                   w_split_first;

   assign hgrant    = r_grant;
   assign hmaster   = r_master;
   assign hmastlock = r_mastlock;

   assign w_gnt_set     = hbusreq & ~r_split_mask;
   assign w_lock_hold   = hlock[w_gidx] & hbusreq[w_gidx];
   assign w_split_first = (hresp == RESP_SPLIT) & ~hready & ~r_in_split;
   assign w_ap          = hready & (r_force_ap | ((r_beat_cnt == 4'd0) & ~w_lock_hold));

   // Encode the one-hot grant register into the current grant index
   always_comb begin
      w_gidx = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (r_grant[i]) w_gidx = w_gidx | IW'(i);
   end

   // Round-robin search: first grantable master above the last one granted, wrapping
   always_comb begin
      w_found    = 1'b0;
      w_next_idx = DEF_IDX;
      w_probe    = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         w_probe = IW'((int'(r_rr_ptr) + k) % NUM_MASTERS);
         if (!w_found && w_gnt_set[w_probe]) begin
            w_found    = 1'b1;
            w_next_idx = w_probe;
         end
      end
   end

   // Remaining beats after the first, per burst type; INCR and SINGLE never hold
   always_comb begin
      case (hburst)
         3'd2, 3'd3: w_burst_len = 4'd3;
         3'd4, 3'd5: w_burst_len = 4'd7;
         3'd6, 3'd7: w_burst_len = 4'd15;
         default:    w_burst_len = 4'd0;
      endcase
   end

   // Next split mask: releases clear, a new SPLIT sets and wins over a same-edge release
   always_comb begin
      w_split_nxt = r_split_mask & ~hsplit;
      if (w_split_first) w_split_nxt[r_master] = 1'b1;
   end

   // Grant and round-robin pointer move only at arbitration points
   always_ff @(posedge hclk or negedge hrst) begin
      if (!hrst) begin
         r_grant  <= DEF_GRANT;
         r_rr_ptr <= DEF_IDX;
      end else if (w_ap) begin
         if (w_found) begin
            r_grant  <= NUM_MASTERS'(1) << w_next_idx;
            r_rr_ptr <= w_next_idx;
         end else begin
            r_grant  <= DEF_GRANT;
         end
      end
   end

   // Address-phase ownership follows the grant on every completed transfer
   always_ff @(posedge hclk or negedge hrst) begin
      if (!hrst) begin
         r_master   <= DEF_IDX;
         r_mastlock <= 1'b0;
      end else if (hready) begin
         r_master   <= w_gidx;
         r_mastlock <= hlock[w_gidx];
      end
   end

   // Burst beat counter; a SPLIT abandons the rest of the burst
   always_ff @(posedge hclk or negedge hrst) begin
      if (!hrst) begin
         r_beat_cnt <= 4'd0;
      end else if (w_split_first) begin
         r_beat_cnt <= 4'd0;
      end else if (hready) begin
         case (htrans)
            TR_NONSEQ: r_beat_cnt <= w_burst_len;
            TR_SEQ:    if (r_beat_cnt != 4'd0) r_beat_cnt <= r_beat_cnt - 4'd1;
            TR_BUSY:   r_beat_cnt <= r_beat_cnt;
            TR_IDLE:   r_beat_cnt <= 4'd0;
            default:   r_beat_cnt <= r_beat_cnt;
         endcase
      end
   end

   // SPLIT bookkeeping: mask update and the forced arbitration point that follows
   always_ff @(posedge hclk or negedge hrst) begin
      if (!hrst) begin
         r_split_mask <= '0;
         r_in_split   <= 1'b0;
         r_force_ap   <= 1'b0;
      end else begin
         r_split_mask <= w_split_nxt;
         if (w_split_first) begin
            r_in_split <= 1'b1;
            r_force_ap <= 1'b1;
         end else if (hready) begin
            r_in_split <= 1'b0;
            r_force_ap <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: scenario bench for ahb_arbiter. Each row drives one cycle of
// bus inputs and pushes the hand-derived {hgrant, hmaster, hmastlock} expected
// after that edge; the row is popped and compared once the edge has passed.
module tb_ahb_arbiter;

   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NS = 2'd2, SQ = 2'd3;
   localparam logic [1:0] OK = 2'd0, RTY = 2'd2, SPL = 2'd3;
   localparam logic [15:0] Z16 = 16'h0000;

   logic        hclk = 1'b0;
   logic        hrst = 1'b1;
   logic [15:0] hbusreq, hlock, hsplit;
   logic [1:0]  htrans, hresp;
   logic [2:0]  hburst;
   logic        hready;
   logic [15:0] hgrant;
   logic [3:0]  hmaster;
   logic        hmastlock;

   typedef struct packed {
      logic [15:0] g;
      logic [3:0]  m;
      logic        l;
   } exp_t;

   typedef struct {
      logic [15:0] req;
      logic [15:0] lck;
      logic [15:0] spl;
      logic [1:0]  tr;
      logic [2:0]  bu;
      logic        rdy;
      logic [1:0]  rsp;
      exp_t        e;
   } stim_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 hclk = ~hclk;

   ahb_arbiter #(.NUM_MASTERS(16), .DEFAULT_MASTER(0)) dut (
      .hclk      (hclk),
      .hrst      (hrst),
      .hbusreq   (hbusreq),
      .hlock     (hlock),
      .hsplit    (hsplit),
      .htrans    (htrans),
      .hburst    (hburst),
      .hready    (hready),
      .hresp     (hresp),
      .hgrant    (hgrant),
      .hmaster   (hmaster),
      .hmastlock (hmastlock)
   );

   function automatic stim_t mk(input logic [15:0] req, input logic [15:0] lck,
                                input logic [15:0] spl, input logic [1:0] tr,
                                input logic [2:0] bu, input logic rdy, input logic [1:0] rsp,
                                input logic [15:0] g, input logic [3:0] m, input logic l);
      stim_t s;
      s.req = req; s.lck = lck; s.spl = spl; s.tr = tr; s.bu = bu;
      s.rdy = rdy; s.rsp = rsp;
      s.e.g = g; s.e.m = m; s.e.l = l;
      return s;
   endfunction

   // Drive one row, queue its expectation, and step to just after the edge
   task automatic apply(input stim_t s);
      hbusreq = s.req; hlock = s.lck; hsplit = s.spl;
      htrans = s.tr; hburst = s.bu; hready = s.rdy; hresp = s.rsp;
      sb.push_back(s.e);
      @(posedge hclk);
      #1;
   endtask

   task automatic test_reset();
      exp_t o, e;
      #1 hrst = 1'b0;
      #1;
      sb.push_back({16'h0001, 4'd0, 1'b0});
      o = {hgrant, hmaster, hmastlock}; e = sb.pop_front(); n_vec++;
      if (o !== e) begin
         n_err++;
         $display("FAIL reset_async: got %h/%0d/%b want %h/%0d/%b", o.g, o.m, o.l, e.g, e.m, e.l);
      end
      @(posedge hclk); #1;
      sb.push_back({16'h0001, 4'd0, 1'b0});
      o = {hgrant, hmaster, hmastlock}; e = sb.pop_front(); n_vec++;
      if (o !== e) begin
         n_err++;
         $display("FAIL reset_held: got %h/%0d/%b want %h/%0d/%b", o.g, o.m, o.l, e.g, e.m, e.l);
      end
      hrst = 1'b1;
   endtask

   task automatic test_round_robin();
      stim_t t[$];
      exp_t  o, e;
      t.push_back(mk(16'h0016, Z16, Z16, NS, 3'd0, 1'b1, OK, 16'h0002, 4'd0, 1'b0));
      t.push_back(mk(16'h0016, Z16, Z16, NS, 3'd0, 1'b1, OK, 16'h0004, 4'd1, 1'b0));
      t.push_back(mk(16'h0016, Z16, Z16, NS, 3'd0, 1'b1, OK, 16'h0010, 4'd2, 1'b0));
      t.push_back(mk(16'h0016, Z16, Z16, NS, 3'd0, 1'b1, OK, 16'h0002, 4'd4, 1'b0));
      t.push_back(mk(16'h0016, Z16, Z16, NS, 3'd0, 1'b1, OK, 16'h0004, 4'd1, 1'b0));
      t.push_back(mk(16'h0016, Z16, Z16, NS, 3'd0, 1'b1, OK, 16'h0010, 4'd2, 1'b0));
      foreach (t[i]) begin
         apply(t[i]);
         o = {hgrant, hmaster, hmastlock}; e = sb.pop_front(); n_vec++;
         if (o !== e) begin
            n_err++;
            $display("FAIL round_robin step %0d: got %h/%0d/%b want %h/%0d/%b", i, o.g, o.m, o.l, e.g, e.m, e.l);
         end
      end
   endtask

   task automatic test_burst();
      stim_t t[$];
      exp_t  o, e;
      t.push_back(mk(16'h0008, Z16, Z16, IDLE, 3'd0, 1'b1, OK, 16'h0008, 4'd4, 1'b0));
      t.push_back(mk(16'h0008, Z16, Z16, NS,   3'd5, 1'b1, OK, 16'h0008, 4'd3, 1'b0));
      for (int k = 0; k < 3; k++)
         t.push_back(mk(16'h0028, Z16, Z16, SQ, 3'd5, 1'b1, OK, 16'h0008, 4'd3, 1'b0));
      for (int k = 0; k < 2; k++)
         t.push_back(mk(16'h0028, Z16, Z16, SQ, 3'd5, 1'b0, OK, 16'h0008, 4'd3, 1'b0));
      for (int k = 0; k < 4; k++)
         t.push_back(mk(16'h0028, Z16, Z16, SQ, 3'd5, 1'b1, OK, 16'h0008, 4'd3, 1'b0));
      t.push_back(mk(16'h0028, Z16, Z16, IDLE, 3'd0, 1'b1, OK, 16'h0020, 4'd3, 1'b0));
      t.push_back(mk(Z16,      Z16, Z16, IDLE, 3'd0, 1'b1, OK, 16'h0001, 4'd5, 1'b0));
      foreach (t[i]) begin
         apply(t[i]);
         o = {hgrant, hmaster, hmastlock}; e = sb.pop_front(); n_vec++;
         if (o !== e) begin
            n_err++;
            $display("FAIL burst_hold step %0d: got %h/%0d/%b want %h/%0d/%b", i, o.g, o.m, o.l, e.g, e.m, e.l);
         end
      end
   endtask

   task automatic test_lock();
      stim_t t[$];
      exp_t  o, e;
      t.push_back(mk(16'h0004, 16'h0004, Z16, IDLE, 3'd0, 1'b1, OK,  16'h0004, 4'd0, 1'b0));
      t.push_back(mk(16'h0084, 16'h0004, Z16, NS,   3'd0, 1'b1, OK,  16'h0004, 4'd2, 1'b1));
      t.push_back(mk(16'h0084, 16'h0004, Z16, NS,   3'd0, 1'b0, RTY, 16'h0004, 4'd2, 1'b1));
      t.push_back(mk(16'h0084, 16'h0004, Z16, NS,   3'd0, 1'b1, RTY, 16'h0004, 4'd2, 1'b1));
      t.push_back(mk(16'h0084, 16'h0004, Z16, NS,   3'd0, 1'b1, OK,  16'h0004, 4'd2, 1'b1));
      t.push_back(mk(16'h0084, Z16,      Z16, NS,   3'd0, 1'b0, OK,  16'h0004, 4'd2, 1'b1));
      t.push_back(mk(16'h0084, Z16,      Z16, NS,   3'd0, 1'b1, OK,  16'h0080, 4'd2, 1'b0));
      t.push_back(mk(Z16,      Z16,      Z16, IDLE, 3'd0, 1'b1, OK,  16'h0001, 4'd7, 1'b0));
      foreach (t[i]) begin
         apply(t[i]);
         o = {hgrant, hmaster, hmastlock}; e = sb.pop_front(); n_vec++;
         if (o !== e) begin
            n_err++;
            $display("FAIL lock_hold step %0d: got %h/%0d/%b want %h/%0d/%b", i, o.g, o.m, o.l, e.g, e.m, e.l);
         end
      end
   endtask

   task automatic test_split();
      stim_t t[$];
      exp_t  o, e;
      t.push_back(mk(16'h0010, Z16, Z16,      NS,   3'd0, 1'b1, OK,  16'h0010, 4'd0, 1'b0));
      t.push_back(mk(16'h0010, Z16, Z16,      NS,   3'd0, 1'b1, OK,  16'h0010, 4'd4, 1'b0));
      t.push_back(mk(16'h0010, Z16, Z16,      NS,   3'd0, 1'b0, SPL, 16'h0010, 4'd4, 1'b0));
      t.push_back(mk(16'h0010, Z16, Z16,      IDLE, 3'd0, 1'b1, SPL, 16'h0001, 4'd4, 1'b0));
      t.push_back(mk(16'h0010, Z16, Z16,      IDLE, 3'd0, 1'b1, OK,  16'h0001, 4'd0, 1'b0));
      t.push_back(mk(16'h0010, Z16, 16'h0010, IDLE, 3'd0, 1'b1, OK,  16'h0001, 4'd0, 1'b0));
      t.push_back(mk(16'h0010, Z16, Z16,      IDLE, 3'd0, 1'b1, OK,  16'h0010, 4'd0, 1'b0));
      foreach (t[i]) begin
         apply(t[i]);
         o = {hgrant, hmaster, hmastlock}; e = sb.pop_front(); n_vec++;
         if (o !== e) begin
            n_err++;
            $display("FAIL split_mask step %0d: got %h/%0d/%b want %h/%0d/%b", i, o.g, o.m, o.l, e.g, e.m, e.l);
         end
      end
   endtask

   task automatic test_split_race();
      stim_t t[$];
      exp_t  o, e;
      t.push_back(mk(16'h0010, Z16, Z16,      NS,   3'd0, 1'b1, OK,  16'h0010, 4'd4, 1'b0));
      t.push_back(mk(16'h0010, Z16, 16'h0010, NS,   3'd0, 1'b0, SPL, 16'h0010, 4'd4, 1'b0));
      t.push_back(mk(16'h0010, Z16, Z16,      IDLE, 3'd0, 1'b1, SPL, 16'h0001, 4'd4, 1'b0));
      t.push_back(mk(16'h0010, Z16, Z16,      IDLE, 3'd0, 1'b1, OK,  16'h0001, 4'd0, 1'b0));
      t.push_back(mk(16'h0010, Z16, 16'h0010, IDLE, 3'd0, 1'b1, OK,  16'h0001, 4'd0, 1'b0));
      t.push_back(mk(16'h0010, Z16, Z16,      IDLE, 3'd0, 1'b1, OK,  16'h0010, 4'd0, 1'b0));
      foreach (t[i]) begin
         apply(t[i]);
         o = {hgrant, hmaster, hmastlock}; e = sb.pop_front(); n_vec++;
         if (o !== e) begin
            n_err++;
            $display("FAIL split_race step %0d: got %h/%0d/%b want %h/%0d/%b", i, o.g, o.m, o.l, e.g, e.m, e.l);
         end
      end
   endtask

   task automatic test_reset_midburst();
      stim_t t[$];
      stim_t p[$];
      exp_t  o, e;
      t.push_back(mk(16'h0010, 16'h0010, Z16, NS, 3'd7, 1'b1, OK, 16'h0010, 4'd4, 1'b1));
      t.push_back(mk(16'h0012, 16'h0010, Z16, SQ, 3'd7, 1'b1, OK, 16'h0010, 4'd4, 1'b1));
      t.push_back(mk(16'h0012, 16'h0010, Z16, SQ, 3'd7, 1'b1, OK, 16'h0010, 4'd4, 1'b1));
      foreach (t[i]) begin
         apply(t[i]);
         o = {hgrant, hmaster, hmastlock}; e = sb.pop_front(); n_vec++;
         if (o !== e) begin
            n_err++;
            $display("FAIL midburst_setup step %0d: got %h/%0d/%b want %h/%0d/%b", i, o.g, o.m, o.l, e.g, e.m, e.l);
         end
      end
      // Reset lands between edges while the locked INCR16 is in flight
      #2 hrst = 1'b0;
      sb.push_back({16'h0001, 4'd0, 1'b0});
      #1;
      o = {hgrant, hmaster, hmastlock}; e = sb.pop_front(); n_vec++;
      if (o !== e) begin
         n_err++;
         $display("FAIL midburst_reset: got %h/%0d/%b want %h/%0d/%b", o.g, o.m, o.l, e.g, e.m, e.l);
      end
      @(posedge hclk); #1;
      hrst = 1'b1;
      // BUSY would preserve a surviving beat count, so these rows expose stale state
      p.push_back(mk(Z16,      Z16, Z16, BUSY, 3'd7, 1'b1, OK, 16'h0001, 4'd0, 1'b0));
      p.push_back(mk(16'h0022, Z16, Z16, BUSY, 3'd7, 1'b1, OK, 16'h0002, 4'd0, 1'b0));
      foreach (p[i]) begin
         apply(p[i]);
         o = {hgrant, hmaster, hmastlock}; e = sb.pop_front(); n_vec++;
         if (o !== e) begin
            n_err++;
            $display("FAIL post_reset step %0d: got %h/%0d/%b want %h/%0d/%b", i, o.g, o.m, o.l, e.g, e.m, e.l);
         end
      end
   endtask

   initial begin
      hbusreq = Z16; hlock = Z16; hsplit = Z16;
      htrans = IDLE; hburst = 3'd0; hready = 1'b1; hresp = OK;
      test_reset();
      test_round_robin();
      test_burst();
      test_lock();
      test_split();
      test_split_race();
      test_reset_midburst();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
